// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the jtkcpu program-counter sequencer.
// - pcseq_state_t : fetch FSM states (RUN / WAIT / DROP)
// - redirect_t    : which redirect source won arbitration this cycle
//                   (priority jmp > br16 > br8 > pul_done)
package jtkcpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,  // idle on the bus, may issue a fetch
    ST_WAIT = 2'd1,  // fetch outstanding, data will be pushed
    ST_DROP = 2'd2   // fetch outstanding, data belongs to a stale stream
  } pcseq_state_t;

  typedef enum logic [2:0] {
    RD_NONE = 3'd0,
    RD_JMP  = 3'd1,
    RD_BR16 = 3'd2,
    RD_BR8  = 3'd3,
    RD_PUL  = 3'd4
  } redirect_t;

  function automatic logic is_branch(redirect_t r);
    return (r == RD_BR16) || (r == RD_BR8);
  endfunction

endpackage

// File: rtl/jtkcpu_pfq.sv
// Prefetch byte queue: QD x 8 circular FIFO (QD a power of two).
// Ports:
//   clk, rst_n, cen   clock, async active-low reset, clock enable
//   push, din         write din at the tail
//   pop               drop the head byte (ignored when empty)
//   flush             empty the queue; wins over push/pop
//   dout, valid       head byte (0 when empty), queue not empty
//   cnt               number of bytes held (0..QD)
module jtkcpu_pfq #(
  parameter int QD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 push,
  input  logic [7:0]           din,
  input  logic                 pop,
  input  logic                 flush,
  output logic [7:0]           dout,
  output logic                 valid,
  output logic [$clog2(QD):0]  cnt
);

  localparam int PW = $clog2(QD);

  logic [7:0]    mem [QD];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (cnt != '0);
  assign do_pop  = pop && valid;
  // A full queue can still accept a byte when the head leaves the same cycle.
  assign do_push = push && ((cnt != (PW+1)'(QD)) || do_pop);
  assign dout    = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (cen) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Storage needs no reset: dout is gated by valid.
  always_ff @(posedge clk) begin
    if (cen && do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtkcpu_pcseq.sv
// Program-counter sequencer with byte prefetch queue.
// Holds the architectural PC (address of the queue head) and keeps
// fetching bytes ahead of it over a req/ack port. Jumps, taken branches
// and pulled PCs redirect the stream and flush the queue.
// Ports:
//   clk, rst_n, cen          clock, async active-low reset, clock enable
//   consume, intsrv          pop head byte (PC+1); intsrv blocks consume
//   q_data, q_valid          head byte (0 when empty), queue not empty
//   br8, br16, br_take, rel  relative branch requests and offset
//   jmp, jmp_addr            absolute jump
//   pul_pc, pul_hi, pul_data byte-serial PC pull into the staging register
//   pul_done                 load PC from staging
//   mem_req, mem_addr        fetch request, held stable until mem_ack
//   mem_ack, mem_din         fetch completion and data
//   pc, busy                 architectural PC, redirect in progress
//
// Bus handshake: mem_req rises with mem_addr already valid; both stay
// unchanged until the cycle mem_ack is sampled high (with cen), after
// which mem_req drops. Exactly one ack is expected per request.
module jtkcpu_pcseq
  import jtkcpu_pkg::*;
#(
  parameter int            AW    = 16,
  parameter int            QD    = 4,
  parameter logic [AW-1:0] RSTPC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          consume,
  input  logic          intsrv,
  output logic [7:0]    q_data,
  output logic          q_valid,
  input  logic          br8,
  input  logic          br16,
  input  logic          br_take,
  input  logic [15:0]   rel,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_addr,
  input  logic          pul_pc,
  input  logic          pul_hi,
  input  logic [7:0]    pul_data,
  input  logic          pul_done,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_din,
  output logic [AW-1:0] pc,
  output logic          busy
);

  localparam int CW = $clog2(QD) + 1;

  pcseq_state_t  state, state_nxt;
  redirect_t     rd_sel;
  logic [AW-1:0] pc_r, fa, stage, stage_nxt, new_pc;
  logic [AW-1:0] rel8_x, rel16_x;
  logic [AW-9:0] pul_hi_x;
  logic [CW-1:0] cnt;
  logic          bdone, busy_r;
  logic          redirect, pop, push, req_set, req_clr;

  assign pc   = pc_r;
  assign busy = busy_r;

  assign rel8_x  = AW'($signed(rel[7:0]));
  assign rel16_x = AW'($signed(rel));

  jtkcpu_pfq #(.QD(QD)) u_pfq (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .push  (push),
    .din   (mem_din),
    .pop   (pop),
    .flush (redirect),
    .dout  (q_data),
    .valid (q_valid),
    .cnt   (cnt)
  );

  // Redirect arbitration, staging update and FSM next state.
  always_comb begin
    pul_hi_x      = '0;
    pul_hi_x[7:0] = pul_data;
    stage_nxt     = stage;
    if (pul_pc) begin
      if (pul_hi) stage_nxt[AW-1:8] = pul_hi_x;
      else        stage_nxt[7:0]    = pul_data;
    end

    rd_sel = RD_NONE;
    new_pc = pc_r;
    if (jmp) begin
      rd_sel = RD_JMP;
      new_pc = jmp_addr;
    end else if (br16 && br_take && !bdone) begin
      rd_sel = RD_BR16;
      new_pc = pc_r + rel16_x;
    end else if (br8 && br_take && !bdone) begin
      rd_sel = RD_BR8;
      new_pc = pc_r + rel8_x;
    end else if (pul_done) begin
      // Same-cycle pul_pc byte is already merged into stage_nxt.
      rd_sel = RD_PUL;
      new_pc = stage_nxt;
    end
    redirect = (rd_sel != RD_NONE);
    pop      = consume && q_valid && !intsrv && !redirect;

    state_nxt = state;
    push      = 1'b0;
    req_set   = 1'b0;
    req_clr   = 1'b0;
    case (state)
      ST_RUN: begin
        if (!redirect && (cnt < CW'(QD))) begin
          req_set   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          // A redirect in the ack cycle makes this byte stale: discard it.
          push      = !redirect;
          req_clr   = 1'b1;
          state_nxt = ST_RUN;
        end else if (redirect) begin
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (mem_ack) begin
          req_clr   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else if (cen) state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r     <= RSTPC;
      fa       <= RSTPC;
      stage    <= '0;
      bdone    <= 1'b0;
      busy_r   <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= RSTPC;
    end else if (cen) begin
      stage <= stage_nxt;
      if (redirect) begin
        pc_r <= new_pc;
        fa   <= new_pc;
      end else begin
        if (pop)  pc_r <= pc_r + 1'b1;
        if (push) fa   <= fa + 1'b1;
      end
      // A held branch strobe is applied once; releasing both strobes re-arms.
      if (!(br8 || br16))        bdone <= 1'b0;
      else if (is_branch(rd_sel)) bdone <= 1'b1;
      // busy covers the gap until the first byte of the new stream lands.
      if (redirect)  busy_r <= 1'b1;
      else if (push) busy_r <= 1'b0;
      if (req_set) begin
        mem_req  <= 1'b1;
        mem_addr <= fa;
      end else if (req_clr) begin
        mem_req  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtkcpu_pcseq.sv
module tb_jtkcpu_pcseq;
  localparam int QD = 4;
  localparam logic [15:0] RSTPC = 16'h8000;

  logic        clk = 1'b0;
  logic        rst_n, cen, consume, intsrv;
  logic [7:0]  q_data;
  logic        q_valid;
  logic        br8, br16, br_take;
  logic [15:0] rel;
  logic        jmp;
  logic [15:0] jmp_addr;
  logic        pul_pc, pul_hi, pul_done;
  logic [7:0]  pul_data;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_din;
  logic [15:0] pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC, expected queue contents, one
  // outstanding fetch (with a stale flag after a redirect), staging, one-shot flag.
  logic [15:0] m_pc, m_fa, m_req_addr, m_stage;
  logic [7:0]  exp_q[$];
  logic        m_out, m_stale, m_bdone, m_busy;
  int          lat_cnt;
  int          ack_lat;    // <0: random latency per request
  logic        force_ack;

  jtkcpu_pcseq #(.AW(16), .QD(QD), .RSTPC(RSTPC)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .consume(consume), .intsrv(intsrv),
    .q_data(q_data), .q_valid(q_valid), .br8(br8), .br16(br16), .br_take(br_take),
    .rel(rel), .jmp(jmp), .jmp_addr(jmp_addr), .pul_pc(pul_pc), .pul_hi(pul_hi),
    .pul_data(pul_data), .pul_done(pul_done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_din(mem_din), .pc(pc), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mem_byte(logic [15:0] a);
    return a[7:0];
  endfunction

  task automatic model_reset();
    m_pc = RSTPC; m_fa = RSTPC; m_req_addr = RSTPC; m_stage = '0;
    exp_q.delete();
    m_out = 0; m_stale = 0; m_bdone = 0; m_busy = 0; lat_cnt = 0;
  endtask

  task automatic clear_inputs();
    cen = 1; consume = 0; intsrv = 0; br8 = 0; br16 = 0; br_take = 0; rel = 0;
    jmp = 0; jmp_addr = 0; pul_pc = 0; pul_hi = 0; pul_data = 0; pul_done = 0;
    force_ack = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic redir, br_app;
    logic [15:0] npc, fa0;
    int sz, off;
    if (!rst_n || !cen) return;
    sz = exp_q.size(); fa0 = m_fa;
    if (pul_pc) begin
      if (pul_hi) m_stage[15:8] = pul_data;
      else        m_stage[7:0]  = pul_data;
    end
    redir = 1; br_app = 0; npc = m_pc;
    if (jmp) npc = jmp_addr;
    else if (br16 && br_take && !m_bdone) begin
      off = int'(rel); if (off > 32767) off -= 65536;
      npc = 16'((int'(m_pc) + off) & 32'hFFFF); br_app = 1;
    end else if (br8 && br_take && !m_bdone) begin
      off = int'(rel[7:0]); if (off > 127) off -= 256;
      npc = 16'((int'(m_pc) + off) & 32'hFFFF); br_app = 1;
    end else if (pul_done) npc = m_stage;
    else redir = 0;
    if (!(br8 || br16)) m_bdone = 0;
    else if (br_app) m_bdone = 1;

    if (redir) begin
      exp_q.delete(); m_pc = npc; m_fa = npc; m_busy = 1;
    end else if (consume && sz > 0 && !intsrv) begin
      void'(exp_q.pop_front()); m_pc = m_pc + 16'd1;
    end

    if (m_out) begin
      if (mem_ack) begin
        if (!m_stale && !redir) begin
          exp_q.push_back(mem_byte(m_req_addr)); m_fa = fa0 + 16'd1; m_busy = 0;
        end
        m_out = 0; m_stale = 0;
      end else if (redir) m_stale = 1;
    end else if (!redir && sz < QD) begin
      m_out = 1; m_stale = 0; m_req_addr = fa0;
      lat_cnt = (ack_lat < 0) ? int'($urandom_range(0, 3)) : ack_lat;
    end
  endtask

  // ---------------- driver: memory responder + one clock ----------------
  task automatic tick();
    mem_ack = 0;
    if (force_ack) begin
      mem_ack = 1; mem_din = 8'hAA;
    end else if (rst_n && cen && m_out) begin
      if (lat_cnt == 0) begin mem_ack = 1; mem_din = mem_byte(mem_addr); end
      else lat_cnt--;
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (pc !== RSTPC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, RSTPC); end
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_qvalid got %b exp 0", q_valid); end
    checks++; if (q_data !== 8'h00) begin errors++; $display("FAIL reset_qdata got %h exp 00", q_data); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
    checks++; if (mem_addr !== RSTPC) begin errors++; $display("FAIL reset_addr got %h exp %h", mem_addr, RSTPC); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_fill();
    int n = 0;
    logic was_req = 0;
    ack_lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req && !was_req) begin
        checks++;
        if (mem_addr !== 16'h8000 + 16'(n)) begin
          errors++; $display("FAIL fill_addr got %h exp %h", mem_addr, 16'h8000 + 16'(n));
        end
        n++;
      end
      was_req = mem_req;
    end
    checks++; if (n != QD) begin errors++; $display("FAIL fill_count got %0d exp %0d", n, QD); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_req_idle got %b exp 0", mem_req); end
    checks++; if (q_valid !== 1'b1 || q_data !== 8'h00) begin errors++; $display("FAIL fill_head got %b/%h exp 1/00", q_valid, q_data); end
    consume = 1; tick(); tick(); consume = 0;
    checks++; if (pc !== 16'h8002) begin errors++; $display("FAIL consume_pc got %h exp 8002", pc); end
    checks++; if (q_data !== 8'h02) begin errors++; $display("FAIL consume_head got %h exp 02", q_data); end
    for (int i = 0; i < 5 && !m_out; i++) tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h8004) begin errors++; $display("FAIL refetch_addr got %b/%h exp 1/8004", mem_req, mem_addr); end
  endtask

  task automatic wait_full();
    for (int i = 0; i < 60 && !(exp_q.size() == QD && !m_out); i++) tick();
    checks++; if (exp_q.size() != QD || m_out) begin errors++; $display("FAIL wait_full timeout got %0d exp %0d", exp_q.size(), QD); end
  endtask

  task automatic test_branch();
    ack_lat = 0;
    jmp = 1; jmp_addr = 16'h1000; tick(); jmp = 0;
    wait_full();
    checks++; if (pc !== 16'h1000 || q_data !== 8'h00) begin errors++; $display("FAIL jmp_1000 got %h/%h exp 1000/00", pc, q_data); end
    br8 = 1; br_take = 1; rel = 16'h00FE;
    tick();
    checks++; if (pc !== 16'h0FFE) begin errors++; $display("FAIL br8_pc got %h exp 0ffe", pc); end
    checks++; if (q_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL br8_flush got v%b b%b exp v0 b1", q_valid, busy); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0FFE) begin errors++; $display("FAIL br8_fetch got %b/%h exp 1/0ffe", mem_req, mem_addr); end
    tick();
    checks++; if (pc !== 16'h0FFE) begin errors++; $display("FAIL br8_oneshot got %h exp 0ffe", pc); end
    br8 = 0; br_take = 0;
    wait_full();
    br8 = 1; br_take = 0; tick(); br8 = 0;
    checks++; if (pc !== 16'h0FFE || q_valid !== 1'b1 || q_data !== 8'hFE || busy !== 1'b0) begin
      errors++; $display("FAIL br8_nottaken got %h/%b/%h/%b exp 0ffe/1/fe/0", pc, q_valid, q_data, busy);
    end
  endtask

  task automatic test_jmp_drop();
    ack_lat = 3;
    consume = 1; tick(); consume = 0;
    for (int i = 0; i < 5 && !m_out; i++) tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h1002) begin errors++; $display("FAIL drop_pre got %b/%h exp 1/1002", mem_req, mem_addr); end
    jmp = 1; jmp_addr = 16'h2345; tick(); jmp = 0;
    for (int i = 0; i < 10 && m_out && m_stale; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h1002 || busy !== 1'b1) begin
        errors++; $display("FAIL drop_hold got %b/%h/%b exp 1/1002/1", mem_req, mem_addr, busy);
      end
      tick();
    end
    for (int i = 0; i < 10 && !m_out; i++) tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h2345) begin errors++; $display("FAIL drop_newaddr got %b/%h exp 1/2345", mem_req, mem_addr); end
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy got %b exp 1", busy); end
      tick();
    end
    checks++; if (q_data !== 8'h45 || busy !== 1'b0 || pc !== 16'h2345) begin
      errors++; $display("FAIL drop_head got %h/%b/%h exp 45/0/2345", q_data, busy, pc);
    end
  endtask

  task automatic test_pull();
    ack_lat = 0;
    wait_full();
    pul_pc = 1; pul_hi = 1; pul_data = 8'h12; tick();
    pul_hi = 0; pul_data = 8'h34; pul_done = 1; tick();
    pul_pc = 0; pul_done = 0;
    checks++; if (pc !== 16'h1234 || q_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL pull_pc got %h/%b/%b exp 1234/0/1", pc, q_valid, busy);
    end
    for (int i = 0; i < 10 && !(m_out && !m_stale); i++) tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h1234) begin errors++; $display("FAIL pull_fetch got %b/%h exp 1/1234", mem_req, mem_addr); end
  endtask

  task automatic test_wrap_priority();
    ack_lat = 0;
    jmp = 1; jmp_addr = 16'hFFFF; tick(); jmp = 0;
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) tick();
    consume = 1; tick(); consume = 0;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h exp 0000", pc); end
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) tick();
    checks++; if (q_data !== 8'h00) begin errors++; $display("FAIL wrap_head got %h exp 00", q_data); end
    jmp = 1; jmp_addr = 16'h0010; tick(); jmp = 0;
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) tick();
    br16 = 1; br_take = 1; rel = 16'h8000; tick(); br16 = 0; br_take = 0;
    checks++; if (pc !== 16'h8010) begin errors++; $display("FAIL br16_pc got %h exp 8010", pc); end
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) tick();
    jmp = 1; jmp_addr = 16'h4000; br16 = 1; br_take = 1; rel = 16'h0100; consume = 1;
    tick();
    jmp = 0; br16 = 0; br_take = 0; consume = 0;
    checks++; if (pc !== 16'h4000) begin errors++; $display("FAIL prio_pc got %h exp 4000", pc); end
  endtask

  task automatic test_intsrv();
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) tick();
    intsrv = 1; consume = 1;
    tick(); tick(); tick();
    intsrv = 0; consume = 0;
    checks++; if (pc !== 16'h4000 || q_valid !== 1'b1 || q_data !== 8'h00) begin
      errors++; $display("FAIL intsrv got %h/%b/%h exp 4000/1/00", pc, q_valid, q_data);
    end
  endtask

  task automatic test_random();
    ack_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      cen      = ($urandom_range(0, 7) != 0);
      consume  = 1'($urandom_range(0, 1));
      intsrv   = ($urandom_range(0, 7) == 0);
      jmp      = ($urandom_range(0, 39) == 0);
      jmp_addr = 16'($urandom);
      if ($urandom_range(0, 5) == 0) br8 = ~br8;
      if ($urandom_range(0, 7) == 0) br16 = ~br16;
      br_take  = 1'($urandom_range(0, 1));
      rel      = 16'($urandom);
      pul_pc   = ($urandom_range(0, 9) == 0);
      pul_hi   = 1'($urandom_range(0, 1));
      pul_data = 8'($urandom);
      pul_done = ($urandom_range(0, 29) == 0);
      tick();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, pc, m_pc); end
      checks++; if (q_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_qvalid cyc %0d got %b exp %0d", i, q_valid, exp_q.size()); end
      if (exp_q.size() > 0) begin
        checks++; if (q_data !== exp_q[0]) begin errors++; $display("FAIL rnd_qdata cyc %0d got %h exp %h", i, q_data, exp_q[0]); end
      end
      checks++; if (mem_req !== m_out) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", i, mem_req, m_out); end
      if (m_out) begin
        checks++; if (mem_addr !== m_req_addr) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, mem_addr, m_req_addr); end
      end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", i, busy, m_busy); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    ack_lat = 3;
    consume = 1;
    for (int i = 0; i < 10 && !m_out; i++) tick();
    consume = 0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", mem_req); end
    #2 rst_n = 0;
    #1;
    checks++; if (mem_req !== 1'b0 || pc !== RSTPC || q_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got %b/%h/%b exp 0/%h/0", mem_req, pc, q_valid, RSTPC);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    force_ack = 1; tick(); force_ack = 0;
    checks++; if (q_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== RSTPC) begin
      errors++; $display("FAIL rstmid_lateack got %b/%b/%h exp 0/1/%h", q_valid, mem_req, mem_addr, RSTPC);
    end
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) tick();
    checks++; if (q_data !== 8'h00 || pc !== RSTPC || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got %h/%h/%b exp 00/%h/0", q_data, pc, busy, RSTPC);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_inputs();
    mem_ack = 0; mem_din = 0; ack_lat = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    test_reset();
    test_fill();
    test_branch();
    test_jmp_drop();
    test_pull();
    test_wrap_priority();
    test_intsrv();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
